ltc_sequencer: RTL and testbench

// - Run/stop/preset controller for the LTC generator. Host loads a BCD start

---
 rtl/ltc_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_ltc_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc_sequencer.sv
// ltc_sequencer
// Run/stop/preset controller for an LTC generator. The host writes a BCD start
// timecode one byte at a time (frames, seconds, minutes, hours), arms the block,
// and starts it either with an external trigger edge or with a direct command.
// The block then pulses load_strobe so the generator loads preset_tc, enables
// the generator, and counts frames, optionally stopping after MAX_FRAMES.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset
//   framerate    00=24 fps, 01=25 fps, 11=30 fps, 10=invalid
//   cmd_valid    command present
//   cmd_ready    command accepted when cmd_valid & cmd_ready
//   cmd_op       00=WRITE_BYTE 01=ARM 10=STOP 11=START_NOW
//   cmd_data     BCD byte for WRITE_BYTE
//   trig_in      external start, rising-edge sensitive
//   frame_tick   one-cycle pulse at each generator frame boundary
//   preset_tc    {hrs_d[1:0],hrs_u,min_d[2:0],min_u,sec_d[2:0],sec_u,frm_d[1:0],frm_u}
//   load_strobe  one-cycle pulse telling the generator to load preset_tc
//   gen_enable   generator counting/output enable
//   state        00=IDLE 01=ARMED 10=RUN
//   preset_ok    complete, valid preset held
//   err          sticky error flag
//   run_frames   frames counted since start, saturating
module ltc_sequencer #(
  parameter int unsigned MAX_FRAMES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  framerate,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  input  logic        trig_in,
  input  logic        frame_tick,
  output logic [25:0] preset_tc,
  output logic        load_strobe,
  output logic        gen_enable,
  output logic [1:0]  state,
  output logic        preset_ok,
  output logic        err,
  output logic [15:0] run_frames
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ARMED = 2'b01;
  localparam logic [1:0] RUN   = 2'b10;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_ARM   = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_START = 2'b11;

  localparam logic [15:0] MAX_F = 16'(MAX_FRAMES);

  logic [1:0]  state_q, state_d;
  logic [25:0] tc_q, tc_d;
  logic [1:0]  idx_q, idx_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        ls_q, ls_d;
  logic        ge_q, ge_d;
  logic [15:0] rf_q, rf_d;
  logic        trig_q;

  logic accept, write_en, tc_d_valid, start, stop;
  logic unused_data_msb;

  // Bit 7 of every BCD byte lies outside all field widths.
  assign unused_data_msb = cmd_data[7];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic tc_valid(input logic [25:0] tc, input logic [1:0] fr);
    logic [3:0] fu, su, mu, hu;
    logic [2:0] sd, md;
    logic [1:0] fd, hd;
    logic [6:0] frames, hours, fps;
    fu = tc[3:0];   fd = tc[5:4];
    su = tc[9:6];   sd = tc[12:10];
    mu = tc[16:13]; md = tc[19:17];
    hu = tc[23:20]; hd = tc[25:24];
    frames = {5'd0, fd} * 7'd10 + {3'd0, fu};
    hours  = {5'd0, hd} * 7'd10 + {3'd0, hu};
    case (fr)
      2'b00:   fps = 7'd24;
      2'b01:   fps = 7'd25;
      2'b11:   fps = 7'd30;
      default: fps = 7'd0;  // reserved rate: nothing is valid
    endcase
    return (fu <= 4'd9) && (su <= 4'd9) && (mu <= 4'd9) && (hu <= 4'd9) &&
           (sd <= 3'd5) && (md <= 3'd5) && (hours < 7'd24) && (frames < fps);
  endfunction

  assign accept   = cmd_valid & cmd_ready;
  assign write_en = accept && (cmd_op == OP_WRITE) && (state_q != RUN);

  // Candidate preset after this cycle's write, if any.
  always_comb begin
    tc_d = tc_q;
    if (write_en) begin
      case (idx_q)
        2'd0:    tc_d[5:0]   = cmd_data[5:0];
        2'd1:    tc_d[12:6]  = cmd_data[6:0];
        2'd2:    tc_d[19:13] = cmd_data[6:0];
        default: tc_d[25:20] = cmd_data[5:0];
      endcase
    end
  end

  assign tc_d_valid = tc_valid(tc_d, framerate);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    err_d   = err_q;
    rf_d    = rf_q;
    ls_d    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;

    if (accept) begin
      case (cmd_op)
        OP_WRITE: begin
          if (state_q == RUN) begin
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd0) begin
              ok_d  = 1'b0;
              err_d = 1'b0;
            end
            if (idx_q == 2'd3) begin
              ok_d = tc_d_valid;
              if (!tc_d_valid) err_d = 1'b1;
            end
            if (state_q == ARMED) state_d = IDLE;
          end
        end
        OP_ARM: begin
          if (state_q == IDLE) begin
            if (ok_q) state_d = ARMED;
            else      err_d   = 1'b1;
          end
        end
        OP_STOP: begin
          stop    = 1'b1;
          state_d = IDLE;
        end
        default: begin
          if ((state_q != RUN) && ok_q) start = 1'b1;
          else                          err_d = 1'b1;
        end
      endcase
    end

    // STOP in the same cycle suppresses a trigger start; a coincident
    // START_NOW and trigger edge collapse into one start.
    if ((state_q == ARMED) && trig_in && !trig_q && !stop) start = 1'b1;

    // Continuous re-validation: a framerate change can invalidate a preset.
    ok_d = ok_d & tc_d_valid;

    if (start) begin
      state_d = RUN;
      ls_d    = 1'b1;
      rf_d    = 16'd0;
    end else if ((state_q == RUN) && frame_tick && !ls_q && !stop) begin
      rf_d = sat_inc16(rf_q);
      if ((MAX_F != 16'd0) && (rf_d == MAX_F)) state_d = IDLE;
    end

    // Enable follows the load strobe by one cycle and drops with RUN.
    ge_d = (state_d == RUN) && (ls_q || ge_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tc_q    <= '0;
      idx_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      ls_q    <= 1'b0;
      ge_q    <= 1'b0;
      rf_q    <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      ls_q    <= ls_d;
      ge_q    <= ge_d;
      rf_q    <= rf_d;
      trig_q  <= trig_in;
    end
  end

  assign cmd_ready   = ~ls_q;
  assign preset_tc   = tc_q;
  assign load_strobe = ls_q;
  assign gen_enable  = ge_q;
  assign state       = state_q;
  assign preset_ok   = ok_q;
  assign err         = err_q;
  assign run_frames  = rf_q;

endmodule

// File: tb/tb_ltc_sequencer.sv
module tb_ltc_sequencer;

  localparam int MAXF = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  framerate = 2'b01;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_data = 8'h00;
  logic        trig_in = 1'b0;
  logic        frame_tick = 1'b0;
  logic [25:0] preset_tc;
  logic        load_strobe;
  logic        gen_enable;
  logic [1:0]  state;
  logic        preset_ok;
  logic        err;
  logic [15:0] run_frames;

  int total = 0;
  int bad   = 0;

  ltc_sequencer #(.MAX_FRAMES(MAXF)) dut (
    .clk(clk), .reset(reset), .framerate(framerate),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .trig_in(trig_in), .frame_tick(frame_tick),
    .preset_tc(preset_tc), .load_strobe(load_strobe), .gen_enable(gen_enable),
    .state(state), .preset_ok(preset_ok), .err(err), .run_frames(run_frames)
  );

  always #5 clk = ~clk;

  // Reference model: stored host bytes, decimal fields, abstract state 0/1/2.
  int mb[4];
  int midx, mstate, mok, merr, mls, mge, mrf, mtp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit mvalid(int b0, int b1, int b2, int b3, int fr);
    int fps;
    fps = (fr == 0) ? 24 : (fr == 1) ? 25 : (fr == 3) ? 30 : 0;
    return ((b0 & 15) <= 9) && ((b1 & 15) <= 9) && ((b2 & 15) <= 9) && ((b3 & 15) <= 9) &&
           (((b1 >> 4) & 7) <= 5) && (((b2 >> 4) & 7) <= 5) &&
           ((((b3 >> 4) & 3) * 10 + (b3 & 15)) < 24) &&
           ((((b0 >> 4) & 3) * 10 + (b0 & 15)) < fps);
  endfunction

  function automatic int mtc();
    return ((mb[3] & 63) << 20) | ((mb[2] & 127) << 13) | ((mb[1] & 127) << 6) | (mb[0] & 63);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mb[i] = 0;
    midx = 0; mstate = 0; mok = 0; merr = 0; mls = 0; mge = 0; mrf = 0; mtp = 0;
  endtask

  task automatic model_step();
    int nb[4];
    int nidx, nstate, nok, nerr, nls, nrf;
    bit acc, stp, st;
    for (int i = 0; i < 4; i++) nb[i] = mb[i];
    nidx = midx; nstate = mstate; nok = mok; nerr = merr; nrf = mrf; nls = 0;
    acc = cmd_valid && (mls == 0);
    stp = 0; st = 0;
    if (acc) begin
      case (int'(cmd_op))
        0: begin
          if (mstate == 2) nerr = 1;
          else begin
            nb[midx] = cmd_data & ((midx == 1 || midx == 2) ? 127 : 63);
            if (midx == 0) begin nok = 0; nerr = 0; end
            if (midx == 3) begin
              nok = mvalid(nb[0], nb[1], nb[2], nb[3], framerate);
              if (nok == 0) nerr = 1;
            end
            nidx = (midx + 1) % 4;
            if (mstate == 1) nstate = 0;
          end
        end
        1: if (mstate == 0) begin
             if (mok != 0) nstate = 1; else nerr = 1;
           end
        2: begin stp = 1; nstate = 0; end
        default: if (mstate != 2 && mok != 0) st = 1; else nerr = 1;
      endcase
    end
    if (mstate == 1 && trig_in && mtp == 0 && !stp) st = 1;
    nok = (nok != 0 && mvalid(nb[0], nb[1], nb[2], nb[3], framerate)) ? 1 : 0;
    if (st) begin
      nstate = 2; nls = 1; nrf = 0;
    end else if (mstate == 2 && frame_tick && mls == 0 && !stp) begin
      nrf = (mrf < 65535) ? mrf + 1 : 65535;
      if (MAXF != 0 && nrf == MAXF) nstate = 0;
    end
    mge = (nstate == 2 && (mls != 0 || mge != 0)) ? 1 : 0;
    for (int i = 0; i < 4; i++) mb[i] = nb[i];
    midx = nidx; mstate = nstate; mok = nok; merr = nerr; mls = nls; mrf = nrf;
    mtp = trig_in;
  endtask

  task automatic check_model();
    chk("state", state, mstate);
    chk("preset_tc", preset_tc, mtc());
    chk("preset_ok", preset_ok, mok);
    chk("err", err, merr);
    chk("load_strobe", load_strobe, mls);
    chk("gen_enable", gen_enable, mge);
    chk("run_frames", run_frames, mrf);
    chk("cmd_ready", cmd_ready, (mls != 0) ? 0 : 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_tc"}, preset_tc, 0);
    chk({tag, "_ok"}, preset_ok, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ls"}, load_strobe, 0);
    chk({tag, "_ge"}, gen_enable, 0);
    chk({tag, "_rf"}, run_frames, 0);
    chk({tag, "_rdy"}, cmd_ready, 1);
  endtask

  // One clock: drive inputs, step the model on the edge, compare after it.
  task automatic cyc(input bit v, input logic [1:0] o, input logic [7:0] d,
                     input bit t, input bit k);
    cmd_valid = v; cmd_op = o; cmd_data = d; trig_in = t; frame_tick = k;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic write4(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    cyc(1, 2'b00, b0, 0, 0);
    cyc(1, 2'b00, b1, 0, 0);
    cyc(1, 2'b00, b2, 0, 0);
    cyc(1, 2'b00, b3, 0, 0);
  endtask

  function automatic logic [7:0] bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  logic [25:0] exp_tc;

  initial begin
    exp_tc = {6'h23, 7'h56, 7'h34, 6'h12};
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals("reset");

    // Valid preset at 25 fps and its bit layout.
    framerate = 2'b01;
    write4(8'h12, 8'h34, 8'h56, 8'h23);
    chk("layout_tc", preset_tc, exp_tc);
    chk("layout_ok", preset_ok, 1);
    chk("layout_err", err, 0);

    // Reserved framerate invalidates the held preset.
    framerate = 2'b10;
    cyc(0, 2'b00, 8'h00, 0, 0);
    chk("fr_drop_ok", preset_ok, 0);

    // Frames 25 at 24 fps is invalid; ARM must then fail.
    framerate = 2'b00;
    write4(8'h25, 8'h00, 8'h00, 8'h00);
    chk("bad_frm_err", err, 1);
    chk("bad_frm_ok", preset_ok, 0);
    cyc(1, 2'b01, 8'h00, 0, 0);
    chk("arm_bad_err", err, 1);
    chk("arm_bad_state", state, 0);

    // Arm then trigger edge; a second edge must not restart.
    framerate = 2'b01;
    write4(8'h12, 8'h34, 8'h56, 8'h23);
    cyc(1, 2'b01, 8'h00, 0, 0);
    chk("armed", state, 1);
    cyc(0, 2'b00, 8'h00, 1, 0);
    chk("trig_ls", load_strobe, 1);
    chk("trig_state", state, 2);
    chk("trig_ge0", gen_enable, 0);
    cyc(0, 2'b00, 8'h00, 1, 0);
    chk("trig_ge1", gen_enable, 1);
    cyc(0, 2'b00, 8'h00, 0, 0);
    cyc(0, 2'b00, 8'h00, 1, 0);
    chk("trig2_ls", load_strobe, 0);

    // Auto-stop after MAXF frames.
    cyc(0, 2'b00, 8'h00, 0, 1);
    cyc(0, 2'b00, 8'h00, 0, 1);
    cyc(0, 2'b00, 8'h00, 0, 1);
    chk("auto_rf", run_frames, 3);
    chk("auto_state", state, 0);
    chk("auto_ge", gen_enable, 0);

    // Write during RUN, then STOP with a coincident frame_tick.
    cyc(1, 2'b11, 8'h00, 0, 0);
    chk("start_now_state", state, 2);
    cyc(0, 2'b00, 8'h00, 0, 1);
    cyc(0, 2'b00, 8'h00, 0, 1);
    cyc(1, 2'b00, 8'h99, 0, 0);
    chk("run_wr_err", err, 1);
    chk("run_wr_tc", preset_tc, exp_tc);
    cyc(1, 2'b10, 8'h00, 0, 1);
    chk("stop_state", state, 0);
    chk("stop_rf", run_frames, 1);

    // Asynchronous reset in the middle of a run.
    write4(8'h12, 8'h34, 8'h56, 8'h23);
    cyc(1, 2'b11, 8'h00, 0, 0);
    cyc(0, 2'b00, 8'h00, 0, 0);
    chk("pre_rst_ge", gen_enable, 1);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    model_reset();
    cmd_valid = 0; trig_in = 0; frame_tick = 0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit v, t, k;
      logic [1:0] o;
      logic [7:0] d;
      int r;
      v = ($urandom % 3) == 0;
      r = $urandom % 10;
      o = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
      if (($urandom % 4) != 0)
        d = bcd((midx == 1 || midx == 2) ? int'($urandom % 60) : int'($urandom % 24)) |
            8'(($urandom % 2) << 7);
      else
        d = 8'($urandom);
      t = ($urandom % 4) == 0;
      k = ($urandom % 3) == 0;
      if (($urandom % 200) == 0) framerate = 2'($urandom);
      cyc(v, o, d, t, k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
